// File: rtl/mem_access_unit.sv
// Load/store unit between a core request port and a single-cycle word-addressed data memory.
// Sub-word stores do a read-merge-write; loads extract the addressed lane and extend it.
module mem_access_unit #(
    parameter int unsigned WORD_IDX_BITS = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic        mem_store,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned AW = WORD_IDX_BITS + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          store_q, store_d;
    logic [1:0]    size_q, size_d;
    logic          unsigned_q, unsigned_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          error_q, error_d;
    logic [31:0]   word_q, word_d;

    logic          req_error_c;
    logic [4:0]    byte_lsb_c;
    logic [4:0]    half_lsb_c;
    logic [7:0]    byte_c;
    logic [15:0]   half_c;
    logic [31:0]   merged_c;
    logic [31:0]   loaded_c;
    logic          unused_addr_hi;

    // Only the word index and the lane offset of the address are ever needed.
    assign unused_addr_hi = ^req_addr[31:AW];

    always_comb begin
        req_error_c = 1'b0;
        case (req_size)
            SZ_BYTE: req_error_c = 1'b0;
            SZ_HALF: req_error_c = req_addr[0];
            SZ_WORD: req_error_c = |req_addr[1:0];
            default: req_error_c = 1'b1;
        endcase
    end

    // Little-endian lane merge for stores and lane extraction/extension for loads.
    always_comb begin
        byte_lsb_c = {addr_q[1:0], 3'b000};
        half_lsb_c = {addr_q[1], 4'b0000};
        byte_c     = word_q[byte_lsb_c +: 8];
        half_c     = word_q[half_lsb_c +: 16];
        merged_c   = word_q;
        loaded_c   = word_q;
        case (size_q)
            SZ_BYTE: begin
                merged_c[byte_lsb_c +: 8] = wdata_q[7:0];
                loaded_c = unsigned_q ? 32'(byte_c) : {{24{byte_c[7]}}, byte_c};
            end
            SZ_HALF: begin
                merged_c[half_lsb_c +: 16] = wdata_q[15:0];
                loaded_c = unsigned_q ? 32'(half_c) : {{16{half_c[15]}}, half_c};
            end
            default: begin
                merged_c = wdata_q;
                loaded_c = word_q;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        error_d    = error_q;
        word_d     = word_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    store_d    = req_store;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr[AW-1:0];
                    wdata_d    = req_wdata;
                    error_d    = req_error_c;
                    if (req_error_c) begin
                        state_d = S_RESP;
                    end else if (req_store && req_size == SZ_WORD) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                word_d  = mem_rdata;
                state_d = store_q ? S_WRITE : S_RESP;
            end
            S_WRITE: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            store_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            error_q    <= 1'b0;
            word_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            error_q    <= error_d;
            word_q     <= word_d;
        end
    end

    // Everything is gated by reset so an in-flight write or response is dropped immediately.
    always_comb begin
        req_ready   = !reset && (state_q == S_IDLE);
        resp_valid  = !reset && (state_q == S_RESP);
        resp_error  = resp_valid && error_q;
        resp_rdata  = (resp_valid && !error_q && !store_q) ? loaded_c : 32'h0;
        mem_store   = !reset && (state_q == S_WRITE);
        mem_wdata   = mem_store ? merged_c : 32'h0;
        mem_address = (!reset && (state_q == S_READ || state_q == S_WRITE))
                      ? 32'(addr_q[AW-1:2]) : 32'h0;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter WORD_IDX_BITS, default 7, meaning the width of the word index driven to the data memory.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, core access request present.
REQ-005 SHALL have port req_ready, output, 1, unit can accept a request.
REQ-006 SHALL have port req_store, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2, 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned, input, 1, 1 = zero-extend loads, 0 = sign-extend loads.
REQ-009 SHALL have port req_addr, input, 32, byte address.
REQ-010 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32, extended load result; 0 for stores and errors.
REQ-013 SHALL have port resp_error, output, 1, misaligned or illegal-size access.
REQ-014 SHALL have port mem_address, output, 32, word index {zeros, addr[WORD_IDX_BITS+1:2]}.
REQ-015 SHALL have port mem_store, output, 1, write strobe to data memory.
REQ-016 SHALL have port mem_wdata, output, 32, full word to write.
REQ-017 SHALL have port mem_rdata, input, 32, combinational read data for mem_address.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-019 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready, and all request fields SHALL be registered on acceptance.
REQ-020 Accepted requests SHALL transition IDLE as follows: error -> RESP; load -> READ; word store -> WRITE; byte/half store -> READ.
REQ-021 An access SHALL be an error if req_size=11, or if half with addr[0]=1, or if word with addr[1:0]!=00.
REQ-022 READ SHALL capture mem_rdata into a word register and then go to RESP for loads or to WRITE for stores.
REQ-023 WRITE SHALL assert mem_store for exactly one cycle with mem_wdata equal to the merged word, then go to RESP.
REQ-024 Merge lanes SHALL be little-endian: a byte store replaces bits [8*addr[1:0]+7 : 8*addr[1:0]] with req_wdata[7:0]; a half store replaces the half selected by addr[1] with req_wdata[15:0]; a word store writes req_wdata unchanged.
REQ-025 Load extraction SHALL use the same lanes, then sign- or zero-extend to 32 bits per req_unsigned; a word load SHALL return the word unchanged.
REQ-026 RESP SHALL assert resp_valid for one cycle, with no backpressure, then return to IDLE.
REQ-027 Latency from the acceptance cycle T SHALL be: error resp at T+1; load resp at T+2; word store strobe at T+1 and resp at T+2; sub-word store read at T+1, strobe at T+2 and resp at T+3.
REQ-028 mem_store SHALL never assert for error accesses, loads, or outside WRITE.
REQ-029 mem_address SHALL hold the registered word index in READ and WRITE, and 0 otherwise.
REQ-030 resp_rdata and resp_error SHALL be 0 whenever resp_valid=0.

Reset
REQ-031 Reset SHALL force state IDLE and clear all registers; during reset, req_ready=0, resp_valid=0, resp_error=0, resp_rdata=0, mem_store=0, mem_address=0 and mem_wdata=0.
REQ-032 mem_store SHALL be gated by !reset, so reset asserted in WRITE suppresses the write; any in-flight request SHALL be dropped without a response.
REQ-033 req_ready SHALL rise in the first cycle after reset deasserts.

Verification
REQ-034 Memory word1=0x00008610; load byte signed at addr 0x5 -> resp at T+2 with resp_rdata=0xFFFFFF86 and resp_error=0.
REQ-035 Memory word1=0x00008610; load half unsigned at addr 0x4 -> resp_rdata=0x00008610; load half signed at addr 0x4 -> resp_rdata=0xFFFF8610.
REQ-036 Memory word0=0x00004430; store byte req_wdata=0x000000AB at addr 0x2 -> single mem_store at T+2 with mem_address=0 and mem_wdata=0x00AB4430, resp at T+3.
REQ-037 Store word 0xDEADBEEF at addr 0xC -> mem_store at T+1 with mem_address=3, resp at T+2; a following load word at 0xC -> resp_rdata=0xDEADBEEF.
REQ-038 Load half at addr 0x3, and separately req_size=11 at addr 0x0 -> resp at T+1 with resp_error=1 and resp_rdata=0; mem_store stays 0 throughout.
REQ-039 Assert reset in the WRITE cycle of a store -> mem_store=0 in that cycle, memory unchanged, no resp_valid, and req_ready=1 in the first cycle after reset deasserts.
